// File: rtl/nbit_or_unit.sv
`default_nettype none
// ============================================================================
//  Module      : nbit_or_unit
//  Description : Registered n-bit bitwise-OR slice of the ALU. Computes a | b
//                and produces the standard N/C/Z/V status flags so the OR
//                result shares the flag path used by the arithmetic units.
//                Result and flags are captured on the rising clock edge when
//                en is high and held otherwise.
//
//  Parameters  : len      - operand/result width in bits (>= 1)
//
//  Ports       : clk      - clock, rising-edge active
//                rst      - asynchronous active-high reset
//                en       - load enable for result and flags
//                a, b     - operands (len bits, unsigned)
//                response - registered a | b (len bits)
//                n        - registered negative flag (MSB of result)
//                c        - registered carry flag (always 0 for OR)
//                z        - registered zero flag
//                v        - registered overflow flag (always 0 for OR)
//
//  Revision    : 1.0 - initial release
// ============================================================================
module nbit_or_unit #(
    parameter int len = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [len-1:0] a,
    input  logic [len-1:0] b,
    output logic [len-1:0] response,
    output logic           n,
    output logic           c,
    output logic           z,
    output logic           v
);

    // A zero-width or negative-width slice is meaningless; stop elaboration.
    if (len < 1) begin : g_len_check
        $error("nbit_or_unit: len must be >= 1");
    end

    localparam logic [len-1:0] c_zero = '0;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    logic [len-1:0] w_res_next;
    logic           w_n_next;
    logic           w_z_next;

    assign w_res_next = a | b;
    assign w_n_next   = w_res_next[len-1];
    assign w_z_next   = (w_res_next == c_zero);

    // ------------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------------
    logic [len-1:0] r_response;
    logic           r_n;
    logic           r_c;
    logic           r_z;
    logic           r_v;

    // Reset state is a zero result, so z comes up set to keep the flags
    // consistent with response from the moment reset asserts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_response <= c_zero;
            r_n        <= 1'b0;
            r_c        <= 1'b0;
            r_z        <= 1'b1;
            r_v        <= 1'b0;
        end else if (en) begin
            r_response <= w_res_next;
            r_n        <= w_n_next;
            // A logical OR can never carry or overflow; these are loaded low
            // so downstream flag muxing treats every unit identically.
            r_c        <= 1'b0;
            r_z        <= w_z_next;
            r_v        <= 1'b0;
        end
    end

    assign response = r_response;
    assign n        = r_n;
    assign c        = r_c;
    assign z        = r_z;
    assign v        = r_v;

endmodule
`default_nettype wire

// File: tb/tb_nbit_or_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nbit_or_unit
//  Description : Self-checking bench for nbit_or_unit at len = 4 and len = 8.
//                Expected results are pushed to a scoreboard queue when the
//                stimulus is driven and popped for comparison after the edge.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nbit_or_unit;

    typedef struct {
        logic [7:0] res;
        logic       n;
        logic       c;
        logic       z;
        logic       v;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;

    logic       en4;
    logic [3:0] a4, b4, resp4;
    logic       n4, c4, z4, v4;

    logic       en8;
    logic [7:0] a8, b8, resp8;
    logic       n8, c8, z8, v8;

    // Bench-side model of the registered result for each width.
    logic [3:0] m4;
    logic [7:0] m8;

    exp_t sb4[$];
    exp_t sb8[$];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    nbit_or_unit #(.len(4)) u_dut4 (
        .clk      (clk),
        .rst      (rst),
        .en       (en4),
        .a        (a4),
        .b        (b4),
        .response (resp4),
        .n        (n4),
        .c        (c4),
        .z        (z4),
        .v        (v4)
    );

    nbit_or_unit #(.len(8)) u_dut8 (
        .clk      (clk),
        .rst      (rst),
        .en       (en8),
        .a        (a8),
        .b        (b8),
        .response (resp8),
        .n        (n8),
        .c        (c8),
        .z        (z8),
        .v        (v8)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check4(input string tag, input exp_t e);
        check_val({tag, ".resp"}, {28'd0, resp4}, {24'd0, e.res});
        check_val({tag, ".n"},    {31'd0, n4},    {31'd0, e.n});
        check_val({tag, ".c"},    {31'd0, c4},    {31'd0, e.c});
        check_val({tag, ".z"},    {31'd0, z4},    {31'd0, e.z});
        check_val({tag, ".v"},    {31'd0, v4},    {31'd0, e.v});
    endtask

    function automatic exp_t mk4(input logic [3:0] r);
        exp_t e;
        e.res = {4'd0, r};
        e.n   = r[3];
        e.c   = 1'b0;
        e.z   = (r == 4'd0);
        e.v   = 1'b0;
        return e;
    endfunction

    function automatic exp_t mk8(input logic [7:0] r);
        exp_t e;
        e.res = r;
        e.n   = r[7];
        e.c   = 1'b0;
        e.z   = (r == 8'd0);
        e.v   = 1'b0;
        return e;
    endfunction

    // Drive one cycle of stimulus on the 4-bit unit and check after the edge.
    task automatic drive4(input string tag, input logic e, input logic [3:0] a, input logic [3:0] b);
        exp_t x;
        @(negedge clk);
        en4 = e;
        a4  = a;
        b4  = b;
        if (e) m4 = a | b;
        sb4.push_back(mk4(m4));
        @(posedge clk);
        #1;
        x = sb4.pop_front();
        check4(tag, x);
    endtask

    task automatic drive8(input string tag, input logic e, input logic [7:0] a, input logic [7:0] b);
        exp_t x;
        @(negedge clk);
        en8 = e;
        a8  = a;
        b8  = b;
        if (e) m8 = a | b;
        sb8.push_back(mk8(m8));
        @(posedge clk);
        #1;
        x = sb8.pop_front();
        check_val({tag, ".resp"}, {24'd0, resp8}, {24'd0, x.res});
        check_val({tag, ".n"},    {31'd0, n8},    {31'd0, x.n});
        check_val({tag, ".c"},    {31'd0, c8},    {31'd0, x.c});
        check_val({tag, ".z"},    {31'd0, z8},    {31'd0, x.z});
        check_val({tag, ".v"},    {31'd0, v8},    {31'd0, x.v});
    endtask

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        en4 = 1'b0; a4 = 4'd0; b4 = 4'd0;
        en8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
        m4  = 4'd0;
        m8  = 8'd0;

        // Reset state, before any clock edge.
        #2;
        check4("reset_init", mk4(4'd0));
        check_val("reset_init8.z", {31'd0, z8}, 32'd1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Basic OR cases.
        drive4("or_3_3", 1'b1, 4'd3, 4'd3);
        drive4("or_2_1", 1'b1, 4'd2, 4'd1);
        drive4("or_7_0", 1'b1, 4'd7, 4'd0);

        // Sign flag.
        drive4("sign_8_0",  1'b1, 4'd8,  4'd0);
        drive4("sign_15_5", 1'b1, 4'd15, 4'd5);

        // Zero flag after a nonzero result.
        drive4("zero_0_0", 1'b1, 4'd0, 4'd0);

        // Enable hold: operands change while en is low.
        drive4("hold_load", 1'b1, 4'd5, 4'd2);
        for (int i = 0; i < 3; i++) drive4("hold_en0", 1'b0, 4'd8, 4'd8);
        drive4("reenable", 1'b1, 4'd8, 4'd8);

        // Asynchronous reset mid-cycle: outputs clear without a clock edge.
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        m4 = 4'd0;
        check4("reset_async", mk4(4'd0));

        // Reset dominates enable across clock edges.
        en4 = 1'b1; a4 = 4'd15; b4 = 4'd15;
        repeat (2) @(posedge clk);
        #1;
        check4("reset_dominates", mk4(4'd0));

        @(negedge clk);
        rst = 1'b0;
        en4 = 1'b0;

        // First capture after reset release.
        drive4("post_reset", 1'b1, 4'd6, 4'd1);

        // Randomised mix of enabled and held cycles.
        for (int i = 0; i < 24; i++) begin
            drive4("random", 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom));
        end

        // Wider instance.
        drive8("w8_80_01", 1'b1, 8'h80, 8'h01);
        drive8("w8_hold",  1'b0, 8'h12, 8'h34);
        drive8("w8_00_00", 1'b1, 8'h00, 8'h00);
        drive8("w8_a5_5a", 1'b1, 8'hA5, 8'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nbit_or_unit.md
# nbit_or_unit

Registered n-bit bitwise-OR slice of the processor ALU. Computes `a | b` and produces the standard ALU status flags N, C, Z and V so the OR result plugs into the same flag path as the arithmetic units. Result and flags are captured on the clock edge when enabled and held otherwise.

## Interface

- `len`, default 4: operand and result width in bits; must be ≥ 1.

Ports:

- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `en`  input  1  load enable; when 1, the next rising edge captures the new result and flags.
- `a`  input  len  operand A, unsigned bit vector.
- `b`  input  len  operand B, unsigned bit vector.
- `response`  output  len  registered `a | b`.
- `n`  output  1  registered negative flag.
- `c`  output  1  registered carry flag.
- `z`  output  1  registered zero flag.
- `v`  output  1  registered overflow flag.

## Operation

- Combinational next-state logic:
  - `res_next = a | b`, bitwise across all `len` bits.
  - `n_next = res_next[len-1]`, the MSB, i.e. the sign bit in two's-complement interpretation.
  - `z_next = 1` iff `res_next == 0`.
  - `c_next = 0` and `v_next = 0`. A logical OR never produces carry or overflow; both flags are forced low so downstream flag muxing is uniform.
- Register update:
  - On a rising `clk` edge with `en = 1`, `response`, `n`, `c`, `z` and `v` load the next-state values.
  - With `en = 0`, all outputs hold.
- No truncation or extension: the result has exactly `len` bits and no carry-out exists.
- Flags are always consistent with `response`:
  - `z == (response == 0)`
  - `n == response[len-1]`
  - This holds at every instant, including after reset.

## Timing

- Latency is 1 clock: operands presented with `en = 1` before edge k appear on the outputs after edge k.
- Throughput is one result per cycle. No handshake beyond `en`, and there are no stall or back-pressure signals.
- Reset, asserted asynchronously, immediately forces:
  - `response = 0`
  - `n = 0`, `c = 0`, `v = 0`
  - `z = 1`, consistent with a zero result.
- Reset dominates `en`: while `rst = 1`, outputs stay at their reset values regardless of `clk`, `en`, `a` and `b`.
- Reset deassertion is synchronous-safe: the first capture occurs on the first rising edge after `rst` falls, provided `en = 1`.
- Reset asserted mid-operation discards any pending result. The value from the edge that coincides with reset assertion is not retained.
- Operand changes while `en = 0` have no effect on the outputs.
- Outputs are driven only from registers. There is no combinational path from `a`, `b` or `en` to any output.

## Test plan

Use `len = 4` unless noted.

- **Reset:** assert `rst` asynchronously mid-cycle → `response = 0000`, `z = 1`, `n = c = v = 0` immediately, without waiting for a clock edge.
- **Basic OR cases:** drive `a = 3, b = 3`; then `a = 2, b = 1`; then `a = 7, b = 0`, each with `en = 1`. After each edge, `response` is `0011`, then `0011`, then `0111`, with `n = c = z = v = 0` in all three cases.
- **Sign flag:** `a = 8, b = 0` → `response = 1000`, `n = 1`, `z = 0`. Then `a = 15, b = 5` → `response = 1111`, `n = 1`, `c = 0`, `v = 0`.
- **Zero flag:** capture `a = 0, b = 0` after a nonzero result → `response = 0000`, `z = 1`, `n = 0`.
- **Enable hold:** capture `a = 5, b = 2` (`response = 0111`), then set `en = 0` and change to `a = 8, b = 8` for 3 edges → outputs stay `0111`, `n = 0`, `z = 0`.
- **Width parameter:** with `len = 8`, `a = 0x80, b = 0x01` → `response = 0x81`, `n = 1`. With `a = 0x00, b = 0x00` → `z = 1`.
